// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit serializer.
package usb_tx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} tx_state_t;

  localparam logic [7:0] SYNC_BYTE       = 8'h80;
  localparam int         STUFF_LIMIT     = 6;
  localparam int         EOP_SE0_BITS    = 2;
  localparam int         FRAC_SHORT_CLKS = 8;
  localparam int         FRAC_LONG_CLKS  = 9;

  // Line state as {D+, D-}.
  typedef logic [1:0] line_t;
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;
endpackage

// File: rtl/usb_tx_bit_timer.sv
// USB bit-period timer: free-runs while the transmitter is active, strobes once per bit.
// USB_TX_FRAC_TIMING_EN selects the 8,8,9 clock pattern instead of CLKS_PER_BIT.
module usb_tx_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int BIT_CNT_W    = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run_i,
  output logic strobe_o
);
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d, term;

`ifdef USB_TX_FRAC_TIMING_EN
  logic [1:0] phase_q, phase_d;

  // Phase is held at 0 while idle so every packet starts on the same pattern.
  assign term = (phase_q == 2'd2) ? BIT_CNT_W'(FRAC_LONG_CLKS - 1)
                                  : BIT_CNT_W'(FRAC_SHORT_CLKS - 1);

  always_comb begin
    phase_d = phase_q;
    if (!run_i)        phase_d = 2'd0;
    else if (strobe_o) phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) phase_q <= 2'd0;
    else        phase_q <= phase_d;
`else
  assign term = BIT_CNT_W'(CLKS_PER_BIT - 1);
`endif

  assign strobe_o = run_i && (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || strobe_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/usb_tx_bit_encoder.sv
// Full-speed USB TX serializer: SYNC, LSB-first bytes with bit stuffing + NRZI, then EOP.
// USB_TX_FRAC_TIMING_EN (in usb_tx_bit_timer) switches to 8,8,9 clock bit periods.
module usb_tx_bit_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int BIT_CNT_W    = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);
  tx_state_t  state_q, state_d;
  line_t      line_q, line_d;
  logic       lvl_q, lvl_d, lvl_n;
  logic [2:0] ones_q, ones_d, idx_q, idx_d, idx_nx;
  logic [7:0] sh_q, sh_d, hold_q, hold_d;
  logic       last_q, last_d, hfull_q, hfull_d, hlast_q, hlast_d;
  logic [1:0] eop_q, eop_d;
  logic       abort_q, abort_d, done_q, done_d, unr_q, unr_d;
  logic       strobe, accept, emit, ebit, load, go_eop;

  usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .BIT_CNT_W(BIT_CNT_W)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .run_i    (state_q != IDLE),
    .strobe_o (strobe)
  );

  assign byte_ready  = !hfull_q && (state_q != EOP_SE0) && (state_q != EOP_J);
  assign accept      = byte_valid && byte_ready;
  assign dplus_out   = line_q[1];
  assign dminus_out  = line_q[0];
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_underrun = unr_q;

  // state_q names the bit currently on the line; each strobe picks the next one.
  always_comb begin
    state_d = state_q;  line_d  = line_q;  lvl_d   = lvl_q;   ones_d = ones_q;
    idx_d   = idx_q;    sh_d    = sh_q;    last_d  = last_q;  hold_d = hold_q;
    hfull_d = hfull_q;  hlast_d = hlast_q; eop_d   = eop_q;   abort_d = abort_q;
    done_d  = 1'b0;     unr_d   = 1'b0;
    emit    = 1'b0;     ebit    = 1'b0;    load    = 1'b0;    go_eop = 1'b0;
    lvl_n   = lvl_q;
    idx_nx  = idx_q + 3'd1;

    if (accept) begin
      hold_d  = byte_data;
      hlast_d = byte_last;
      hfull_d = 1'b1;
    end

    case (state_q)
      IDLE: if (accept) begin
        state_d = SYNC;  idx_d = '0;  ones_d = '0;  abort_d = 1'b0;
        emit    = 1'b1;  ebit  = SYNC_BYTE[0];
      end
      SYNC: if (strobe) begin
        if (idx_q == 3'd7) load = 1'b1;
        else begin
          idx_d = idx_nx;  emit = 1'b1;  ebit = SYNC_BYTE[idx_nx];
        end
      end
      DATA, STUFF: if (strobe) begin
        if (ones_q == 3'(STUFF_LIMIT)) begin
          state_d = STUFF;  emit = 1'b1;  ebit = 1'b0;
        end else if (idx_q != 3'd7) begin
          state_d = DATA;  idx_d = idx_nx;  emit = 1'b1;  ebit = sh_q[idx_nx];
        end else if (last_q)  go_eop = 1'b1;
        else if (hfull_q)     load   = 1'b1;
        else begin
          unr_d = 1'b1;  abort_d = 1'b1;  go_eop = 1'b1;
        end
      end
      EOP_SE0: if (strobe) begin
        if (eop_q == 2'(EOP_SE0_BITS - 1)) begin
          state_d = EOP_J;  line_d = LINE_J;
        end else eop_d = eop_q + 2'd1;
      end
      EOP_J: if (strobe) begin
        state_d = IDLE;  done_d = !abort_q;  lvl_d = 1'b1;  ones_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = DATA;  sh_d = hold_q;  last_d = hlast_q;  hfull_d = 1'b0;
      idx_d   = '0;    emit = 1'b1;    ebit   = hold_q[0];
    end
    // Anything still held when EOP starts belongs to no packet and is dropped.
    if (go_eop) begin
      state_d = EOP_SE0;  eop_d = '0;  hfull_d = 1'b0;  line_d = LINE_SE0;
    end
    if (emit) begin
      lvl_n  = ebit ? lvl_q : ~lvl_q;
      lvl_d  = lvl_n;
      line_d = lvl_n ? LINE_J : LINE_K;
      ones_d = ebit ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;  line_q  <= LINE_J;  lvl_q   <= 1'b1;  ones_q <= '0;
      idx_q   <= '0;    sh_q    <= '0;      last_q  <= 1'b0;  hold_q <= '0;
      hfull_q <= 1'b0;  hlast_q <= 1'b0;    eop_q   <= '0;    abort_q <= 1'b0;
      done_q  <= 1'b0;  unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;  line_q  <= line_d;  lvl_q   <= lvl_d;   ones_q <= ones_d;
      idx_q   <= idx_d;    sh_q    <= sh_d;    last_q  <= last_d;  hold_q <= hold_d;
      hfull_q <= hfull_d;  hlast_q <= hlast_d; eop_q   <= eop_d;   abort_q <= abort_d;
      done_q  <= done_d;   unr_q   <= unr_d;
    end
  end
endmodule
